// File: rtl/arm_pipe_pkg.sv
// Shared pipeline types for the D/E boundary: condition codes, flag bit
// positions and the E-stage control word.
package arm_pipe_pkg;

  localparam int unsigned COND_W  = 4;
  localparam int unsigned FLAG_W  = 4;
  localparam int unsigned ALUC_W  = 4;
  localparam int unsigned FLAGW_W = 2;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [COND_W-1:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic               pcs;
    logic               regw;
    logic               memw;
    logic               memtoreg;
    logic               alusrc;
    logic               branch;
    logic               nowrite;
    logic [FLAGW_W-1:0] flagw;
    logic [ALUC_W-1:0]  alucontrol;
    cond_e              cond;
  } ctrl_e_t;

  // Bubble: no side effects, condition AL so it never looks like an annul.
  localparam ctrl_e_t CTRL_BUBBLE = '{
    pcs:        1'b0,
    regw:       1'b0,
    memw:       1'b0,
    memtoreg:   1'b0,
    alusrc:     1'b0,
    branch:     1'b0,
    nowrite:    1'b0,
    flagw:      FLAGW_W'(0),
    alucontrol: ALUC_W'(0),
    cond:       AL
  };

endpackage

// File: rtl/cond_check.sv
// Combinational condition-code evaluator: does the instruction execute
// given its cond field and the current {N,Z,C,V}?
module cond_check
  import arm_pipe_pkg::*;
#(
  parameter bit NV_EXEC = 1'b0
) (
  input  logic [COND_W-1:0] cond,
  input  logic [FLAG_W-1:0] flags,
  output logic              pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      EQ: pass = z;
      NE: pass = ~z;
      CS: pass = c;
      CC: pass = ~c;
      MI: pass = n;
      PL: pass = ~n;
      VS: pass = v;
      VC: pass = ~v;
      HI: pass = c & ~z;
      LS: pass = ~c | z;
      GE: pass = (n == v);
      LT: pass = (n != v);
      GT: pass = ~z & (n == v);
      LE: pass = z | (n != v);
      AL: pass = 1'b1;
      NV: pass = NV_EXEC;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_cond_stage.sv
// D/E control pipeline register with E-stage conditional execution and the
// architectural NZCV flags register.
module ex_cond_stage
  import arm_pipe_pkg::*;
#(
  parameter logic [3:0] FLAG_RESET = 4'b0000,
  parameter bit         NV_EXEC    = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                StallE,
  input  logic                FlushE,
  input  logic [COND_W-1:0]   CondD,
  input  logic                PCSD,
  input  logic                RegWD,
  input  logic                MemWD,
  input  logic                MemtoRegD,
  input  logic                ALUSrcD,
  input  logic                BranchD,
  input  logic                NoWriteD,
  input  logic [FLAGW_W-1:0]  FlagWD,
  input  logic [ALUC_W-1:0]   ALUControlD,
  input  logic [FLAG_W-1:0]   ALUFlags,
  output logic [ALUC_W-1:0]   ALUControlE,
  output logic                ALUSrcE,
  output logic                MemtoRegE,
  output logic                RegWriteE,
  output logic                MemWriteE,
  output logic                PCSrcE,
  output logic                BranchTakenE,
  output logic                CondExE,
  output logic [FLAG_W-1:0]   FlagsE
);

  ctrl_e_t            ctrl_d;
  ctrl_e_t            ctrl_e;
  logic [FLAG_W-1:0]  flags;
  logic               upd_nz;
  logic               upd_cv;

  assign ctrl_d = '{
    pcs:        PCSD,
    regw:       RegWD,
    memw:       MemWD,
    memtoreg:   MemtoRegD,
    alusrc:     ALUSrcD,
    branch:     BranchD,
    nowrite:    NoWriteD,
    flagw:      FlagWD,
    alucontrol: ALUControlD,
    cond:       cond_e'(CondD)
  };

  // E register: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (reset)        ctrl_e <= CTRL_BUBBLE;
    else if (FlushE)  ctrl_e <= CTRL_BUBBLE;
    else if (!StallE) ctrl_e <= ctrl_d;
  end

  cond_check #(
    .NV_EXEC (NV_EXEC)
  ) u_cond_check (
    .cond  (ctrl_e.cond),
    .flags (flags),
    .pass  (CondExE)
  );

  // Enables are qualified by the condition so an annulled or bubble slot
  // can never write x into the flags.
  assign upd_nz = ~StallE & CondExE & ctrl_e.flagw[1];
  assign upd_cv = ~StallE & CondExE & ctrl_e.flagw[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= FLAG_RESET;
    end else begin
      if (upd_nz) flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (upd_cv) flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

  assign ALUControlE  = ctrl_e.alucontrol;
  assign ALUSrcE      = ctrl_e.alusrc;
  assign MemtoRegE    = ctrl_e.memtoreg;
  assign RegWriteE    = ctrl_e.regw & CondExE & ~ctrl_e.nowrite;
  assign MemWriteE    = ctrl_e.memw & CondExE;
  assign PCSrcE       = ctrl_e.pcs & CondExE;
  assign BranchTakenE = ctrl_e.branch & CondExE;
  assign FlagsE       = flags;

endmodule

// File: tb/tb_ex_cond_stage.sv
// Self-checking bench for ex_cond_stage: directed scenarios plus a random run,
// both checked against an instruction-level reference model.
module tb_ex_cond_stage;

  typedef struct packed {
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       memtoreg;
    logic       alusrc;
    logic       branch;
    logic       nowrite;
    logic [1:0] flagw;
    logic [3:0] aluc;
    logic [3:0] cond;
  } instr_t;

  localparam instr_t NOP = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 4'hE};

  logic       clk;
  logic       reset;
  logic       stall;
  logic       flush;
  logic [3:0] aluflags;
  instr_t     d;

  logic [3:0] aluc0, aluc1;
  logic       alusrc0, alusrc1, m2r0, m2r1;
  logic       regw0, regw1, memw0, memw1, pcs0, pcs1, bt0, bt1, cex0, cex1;
  logic [3:0] flags0, flags1;

  // Reference state: the instruction sitting in E and each instance's flags.
  instr_t     m_e;
  logic [3:0] m_f0, m_f1;

  int tot = 0;
  int bad = 0;

  ex_cond_stage #(.FLAG_RESET(4'b0000), .NV_EXEC(1'b0)) dut0 (
    .clk(clk), .reset(reset), .StallE(stall), .FlushE(flush),
    .CondD(d.cond), .PCSD(d.pcs), .RegWD(d.regw), .MemWD(d.memw),
    .MemtoRegD(d.memtoreg), .ALUSrcD(d.alusrc), .BranchD(d.branch),
    .NoWriteD(d.nowrite), .FlagWD(d.flagw), .ALUControlD(d.aluc),
    .ALUFlags(aluflags),
    .ALUControlE(aluc0), .ALUSrcE(alusrc0), .MemtoRegE(m2r0),
    .RegWriteE(regw0), .MemWriteE(memw0), .PCSrcE(pcs0),
    .BranchTakenE(bt0), .CondExE(cex0), .FlagsE(flags0)
  );

  ex_cond_stage #(.FLAG_RESET(4'b0000), .NV_EXEC(1'b1)) dut1 (
    .clk(clk), .reset(reset), .StallE(stall), .FlushE(flush),
    .CondD(d.cond), .PCSD(d.pcs), .RegWD(d.regw), .MemWD(d.memw),
    .MemtoRegD(d.memtoreg), .ALUSrcD(d.alusrc), .BranchD(d.branch),
    .NoWriteD(d.nowrite), .FlagWD(d.flagw), .ALUControlD(d.aluc),
    .ALUFlags(aluflags),
    .ALUControlE(aluc1), .ALUSrcE(alusrc1), .MemtoRegE(m2r1),
    .RegWriteE(regw1), .MemWriteE(memw1), .PCSrcE(pcs1),
    .BranchTakenE(bt1), .CondExE(cex1), .FlagsE(flags1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Condition truth: pairs of codes share a base test, odd code inverts it.
  function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f, input bit nv);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return nv;
    if (c == 4'hE) return 1'b1;
    return base ^ c[0];
  endfunction

  function automatic logic [3:0] ref_flags(input logic [3:0] f, input instr_t e, input bit nv,
                                           input logic [3:0] alu, input bit st);
    logic [3:0] r;
    r = f;
    if (!st && ref_pass(e.cond, f, nv)) begin
      if (e.flagw[1]) r[3:2] = alu[3:2];
      if (e.flagw[0]) r[1:0] = alu[1:0];
    end
    return r;
  endfunction

  logic exp_cex0, exp_cex1;
  assign exp_cex0 = ref_pass(m_e.cond, m_f0, 1'b0);
  assign exp_cex1 = ref_pass(m_e.cond, m_f1, 1'b1);

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic step();
    instr_t     n_e;
    logic [3:0] n_f0, n_f1;
    if (reset) begin
      n_e = NOP; n_f0 = 4'h0; n_f1 = 4'h0;
    end else begin
      n_f0 = ref_flags(m_f0, m_e, 1'b0, aluflags, stall);
      n_f1 = ref_flags(m_f1, m_e, 1'b1, aluflags, stall);
      n_e  = flush ? NOP : (stall ? m_e : d);
    end
    @(posedge clk);
    m_e = n_e; m_f0 = n_f0; m_f1 = n_f1;
    #1;
  endtask

  function automatic instr_t mk(input bit pcs, input bit regw, input bit memw, input bit branch,
                                input bit nowrite, input logic [1:0] flagw,
                                input logic [3:0] aluc, input logic [3:0] cond);
    instr_t i;
    i = NOP;
    i.pcs = pcs; i.regw = regw; i.memw = memw; i.branch = branch;
    i.nowrite = nowrite; i.flagw = flagw; i.aluc = aluc; i.cond = cond;
    return i;
  endfunction

  function automatic instr_t rnd_instr();
    instr_t i;
    i = instr_t'($urandom);
    return i;
  endfunction

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      d = rnd_instr(); aluflags = 4'($urandom);
      step();
    end
    tot++; if (flags0 !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", flags0); end
    tot++; if ({regw0, memw0, pcs0, bt0} !== 4'b0000) begin bad++;
      $display("FAIL reset_gated got=%b exp=0000", {regw0, memw0, pcs0, bt0}); end
    tot++; if (cex0 !== 1'b1 || cex1 !== 1'b1) begin bad++;
      $display("FAIL reset_condex got=%b%b exp=11", cex0, cex1); end
    tot++; if (aluc0 !== 4'h0) begin bad++; $display("FAIL reset_aluc got=%h exp=0", aluc0); end
    reset = 1'b0;
  endtask

  task automatic test_producer_consumer();
    bit         exp_bt [2];
    logic [3:0] af     [2];
    af[0] = 4'b0110; af[1] = 4'b0010; exp_bt[0] = 1'b1; exp_bt[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      d = mk(0, 1, 0, 0, 0, 2'b11, 4'b0001, 4'hE);          // SUBS
      step();
      aluflags = af[k];
      d = mk(1, 0, 0, 1, 0, 2'b00, 4'b0000, 4'h0);          // BEQ
      step();
      tot++; if (flags0 !== af[k]) begin bad++;
        $display("FAIL pc_flags[%0d] got=%b exp=%b", k, flags0, af[k]); end
      tot++; if (bt0 !== exp_bt[k] || pcs0 !== exp_bt[k]) begin bad++;
        $display("FAIL pc_branch[%0d] got bt=%b pcs=%b exp=%b", k, bt0, pcs0, exp_bt[k]); end
      d = NOP; aluflags = 4'hF;
      step();
    end
  endtask

  task automatic test_annul();
    d = mk(0, 1, 0, 0, 0, 2'b11, 4'h0, 4'hE);               // MOVS sets 1000
    step();
    aluflags = 4'b1000;
    d = mk(0, 1, 0, 0, 0, 2'b11, 4'h0, 4'hA);               // ADDGE
    step();
    tot++; if (cex0 !== 1'b0 || regw0 !== 1'b0) begin bad++;
      $display("FAIL annul_gate got cex=%b regw=%b exp=0 0", cex0, regw0); end
    aluflags = 4'b0100; d = NOP;
    step();
    tot++; if (flags0 !== 4'b1000) begin bad++; $display("FAIL annul_flags got=%b exp=1000", flags0); end
  endtask

  task automatic test_cmp_partial();
    d = mk(0, 1, 0, 0, 1, 2'b11, 4'b0001, 4'hE);            // CMP
    step();
    tot++; if (regw0 !== 1'b0 || cex0 !== 1'b1) begin bad++;
      $display("FAIL cmp_nowrite got regw=%b cex=%b exp=0 1", regw0, cex0); end
    aluflags = 4'b1010;
    d = mk(0, 1, 0, 0, 0, 2'b10, 4'b0010, 4'hE);            // ANDS, N/Z only
    step();
    tot++; if (flags0 !== 4'b1010) begin bad++; $display("FAIL cmp_flags got=%b exp=1010", flags0); end
    aluflags = 4'b0111; d = NOP;
    step();
    tot++; if (flags0 !== 4'b0110) begin bad++; $display("FAIL partial_flags got=%b exp=0110", flags0); end
  endtask

  task automatic test_stall();
    logic [3:0] held;
    d = mk(0, 1, 0, 0, 0, 2'b11, 4'b0000, 4'hE);            // ADDS
    step();
    held = flags0;
    stall = 1'b1;
    d = mk(0, 0, 0, 0, 0, 2'b00, 4'b0100, 4'hE);
    for (int k = 0; k < 3; k++) begin
      aluflags = ~held ^ 4'(k);
      step();
      tot++; if (regw0 !== 1'b1 || aluc0 !== 4'b0000 || cex0 !== 1'b1) begin bad++;
        $display("FAIL stall_hold[%0d] got regw=%b aluc=%h cex=%b exp=1 0 1", k, regw0, aluc0, cex0); end
      tot++; if (flags0 !== held) begin bad++;
        $display("FAIL stall_flags[%0d] got=%b exp=%b", k, flags0, held); end
    end
    stall = 1'b0; aluflags = 4'b1001;
    step();
    tot++; if (flags0 !== 4'b1001 || aluc0 !== 4'b0100) begin bad++;
      $display("FAIL stall_release got flags=%b aluc=%h exp=1001 4", flags0, aluc0); end
    aluflags = 4'b0110; d = NOP;
    step();
    tot++; if (flags0 !== 4'b1001) begin bad++; $display("FAIL stall_once got=%b exp=1001", flags0); end
  endtask

  task automatic test_flush();
    d = mk(0, 0, 1, 0, 0, 2'b00, 4'h0, 4'hE);               // STR
    flush = 1'b1;
    step();
    flush = 1'b0;
    tot++; if (memw0 !== 1'b0) begin bad++; $display("FAIL flush_memw got=%b exp=0", memw0); end
    d = mk(0, 1, 0, 0, 0, 2'b11, 4'b0001, 4'hE);            // SUBS
    step();
    aluflags = 4'b0101; flush = 1'b1; d = mk(0, 0, 1, 0, 0, 2'b00, 4'h0, 4'hE);
    step();
    tot++; if (flags0 !== 4'b0101 || memw0 !== 1'b0) begin bad++;
      $display("FAIL flush_leaving got flags=%b memw=%b exp=0101 0", flags0, memw0); end
    flush = 1'b0; d = mk(0, 1, 0, 0, 0, 2'b11, 4'b0011, 4'hE);
    step();
    stall = 1'b1; flush = 1'b1; aluflags = 4'b1010; d = mk(0, 0, 1, 0, 0, 2'b00, 4'h0, 4'hE);
    step();
    stall = 1'b0; flush = 1'b0;
    tot++; if (flags0 !== 4'b0101) begin bad++; $display("FAIL stallflush_flags got=%b exp=0101", flags0); end
    tot++; if ({regw0, memw0, cex0} !== 3'b001 || aluc0 !== 4'h0) begin bad++;
      $display("FAIL stallflush_bubble got=%b aluc=%h exp=001 0", {regw0, memw0, cex0}, aluc0); end
    d = mk(0, 1, 0, 0, 0, 2'b11, 4'h0, 4'hF);               // cond NV
    step();
    tot++; if (cex0 !== 1'b0 || regw0 !== 1'b0) begin bad++;
      $display("FAIL nv0 got cex=%b regw=%b exp=0 0", cex0, regw0); end
    tot++; if (cex1 !== 1'b1 || regw1 !== 1'b1) begin bad++;
      $display("FAIL nv1 got cex=%b regw=%b exp=1 1", cex1, regw1); end
    aluflags = 4'b1111; d = NOP;
    step();
    tot++; if (flags0 !== 4'b0101 || flags1 !== 4'b1111) begin bad++;
      $display("FAIL nv_flags got=%b/%b exp=0101/1111", flags0, flags1); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      d        = rnd_instr();
      aluflags = 4'($urandom);
      stall    = ($urandom_range(0, 5) == 0);
      flush    = ($urandom_range(0, 6) == 0);
      reset    = ($urandom_range(0, 80) == 0);
      step();
      tot++; if (flags0 !== m_f0 || flags1 !== m_f1) begin bad++;
        $display("FAIL rnd_flags[%0d] got=%b/%b exp=%b/%b", k, flags0, flags1, m_f0, m_f1); end
      tot++; if (cex0 !== exp_cex0 || cex1 !== exp_cex1) begin bad++;
        $display("FAIL rnd_condex[%0d] got=%b%b exp=%b%b", k, cex0, cex1, exp_cex0, exp_cex1); end
      tot++; if (regw0 !== (m_e.regw && exp_cex0 && !m_e.nowrite)) begin bad++;
        $display("FAIL rnd_regw[%0d] got=%b", k, regw0); end
      tot++; if (memw0 !== (m_e.memw && exp_cex0) || pcs0 !== (m_e.pcs && exp_cex0)) begin bad++;
        $display("FAIL rnd_memw_pcs[%0d] got=%b%b", k, memw0, pcs0); end
      tot++; if (bt0 !== (m_e.branch && exp_cex0) || bt1 !== (m_e.branch && exp_cex1)) begin bad++;
        $display("FAIL rnd_branch[%0d] got=%b%b", k, bt0, bt1); end
      tot++; if (aluc0 !== m_e.aluc || alusrc0 !== m_e.alusrc || m2r0 !== m_e.memtoreg) begin bad++;
        $display("FAIL rnd_fields[%0d] got aluc=%h src=%b m2r=%b exp=%h %b %b",
                 k, aluc0, alusrc0, m2r0, m_e.aluc, m_e.alusrc, m_e.memtoreg); end
    end
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; aluflags = 4'h0; d = NOP;
    m_e = NOP; m_f0 = 4'h0; m_f1 = 4'h0;
    test_reset();
    test_producer_consumer();
    test_annul();
    test_cmp_partial();
    test_stall();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
